// File: rtl/multi_chan_link_monitor.sv
// Per-channel Aurora link monitor: event counters, loopback control and a
// link-down watchdog, all accessed over the io_* programming interface.
module multi_chan_link_monitor #(
    parameter int unsigned NUM_CHAN       = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  io_clk,
    input  logic                  io_reset,
    input  logic                  io_sel,
    input  logic                  io_sync,
    input  logic [19:0]           io_addr,
    input  logic                  io_rd_en,
    input  logic                  io_wr_en,
    input  logic [31:0]           io_wr_data,
    output logic [31:0]           io_rd_data,
    output logic                  io_rd_ack,
    input  logic [NUM_CHAN-1:0]   frame_err,
    input  logic [NUM_CHAN-1:0]   hard_err,
    input  logic [NUM_CHAN-1:0]   soft_err,
    input  logic [NUM_CHAN-1:0]   channel_up,
    input  logic [NUM_CHAN-1:0]   lane_up,
    output logic [3*NUM_CHAN-1:0] loopback_set,
    output logic [NUM_CHAN-1:0]   link_reset_req,
    output logic                  link_down_any
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] REG_STATUS   = 4'd0;
    localparam logic [3:0] REG_SOFT     = 4'd1;
    localparam logic [3:0] REG_HARD     = 4'd2;
    localparam logic [3:0] REG_FRAME    = 4'd3;
    localparam logic [3:0] REG_DROP     = 4'd4;
    localparam logic [3:0] REG_LOOPBACK = 4'd5;
    localparam logic [3:0] REG_CTRL     = 4'd6;

    logic [3:0] acc_chan;
    logic [3:0] acc_reg;
    logic       wr_stb;
    logic       rd_stb;

    logic [NUM_CHAN-1:0] soft_q;
    logic [NUM_CHAN-1:0] hard_q;
    logic [NUM_CHAN-1:0] frame_q;
    logic [NUM_CHAN-1:0] chan_q;
    logic [NUM_CHAN-1:0] timeout_flag;

    logic [CNT_WIDTH-1:0] soft_cnt  [NUM_CHAN];
    logic [CNT_WIDTH-1:0] hard_cnt  [NUM_CHAN];
    logic [CNT_WIDTH-1:0] frame_cnt [NUM_CHAN];
    logic [CNT_WIDTH-1:0] drop_cnt  [NUM_CHAN];
    logic [TIMER_W-1:0]   wd_timer  [NUM_CHAN];

    logic [NUM_CHAN-1:0] clr_cnt;
    logic [NUM_CHAN-1:0] clr_flag;
    logic [NUM_CHAN-1:0] wr_lb;
    logic [NUM_CHAN-1:0] wd_fire;
    logic [31:0]         rd_word;

    logic unused_bits;
    assign unused_bits = ^{io_addr[19:8], io_wr_data[31:3]};

    assign acc_chan = io_addr[7:4];
    assign acc_reg  = io_addr[3:0];
    // A combined read+write strobe is a write and never acks.
    assign wr_stb   = io_sync & io_sel & io_wr_en;
    assign rd_stb   = io_sync & io_sel & io_rd_en & ~io_wr_en;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 clr,
        input logic                 ev
    );
        if (clr) begin
            return '0;
        end
        if (ev && (cur != {CNT_WIDTH{1'b1}})) begin
            return cur + CNT_WIDTH'(1);
        end
        return cur;
    endfunction

    // Write decode; unmapped channels never match and are dropped.
    always_comb begin
        clr_cnt  = '0;
        clr_flag = '0;
        wr_lb    = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (wr_stb && (acc_chan == 4'(c))) begin
                wr_lb[c]    = (acc_reg == REG_LOOPBACK);
                clr_cnt[c]  = (acc_reg == REG_CTRL) && io_wr_data[0];
                clr_flag[c] = (acc_reg == REG_CTRL) && io_wr_data[1];
            end
        end
    end

    always_comb begin
        wd_fire = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            wd_fire[c] = ~channel_up[c] && (wd_timer[c] == TIMER_LAST);
        end
    end

    // Input delay registers, saturating counters and watchdog timers.
    always_ff @(posedge io_clk or posedge io_reset) begin
        if (io_reset) begin
            soft_q       <= '0;
            hard_q       <= '0;
            frame_q      <= '0;
            chan_q       <= '0;
            timeout_flag <= '0;
            for (int c = 0; c < NUM_CHAN; c++) begin
                soft_cnt[c]  <= '0;
                hard_cnt[c]  <= '0;
                frame_cnt[c] <= '0;
                drop_cnt[c]  <= '0;
                wd_timer[c]  <= '0;
            end
        end else begin
            soft_q  <= soft_err;
            hard_q  <= hard_err;
            frame_q <= frame_err;
            chan_q  <= channel_up;
            // A fire in the same cycle as a clear keeps the flag set.
            timeout_flag <= wd_fire | (timeout_flag & ~clr_flag);
            for (int c = 0; c < NUM_CHAN; c++) begin
                soft_cnt[c]  <= cnt_next(soft_cnt[c],  clr_cnt[c], soft_err[c]  & ~soft_q[c]);
                hard_cnt[c]  <= cnt_next(hard_cnt[c],  clr_cnt[c], hard_err[c]  & ~hard_q[c]);
                frame_cnt[c] <= cnt_next(frame_cnt[c], clr_cnt[c], frame_err[c] & ~frame_q[c]);
                drop_cnt[c]  <= cnt_next(drop_cnt[c],  clr_cnt[c], ~channel_up[c] & chan_q[c]);
                if (channel_up[c] || wd_fire[c]) begin
                    wd_timer[c] <= '0;
                end else begin
                    wd_timer[c] <= wd_timer[c] + TIMER_W'(1);
                end
            end
        end
    end

    always_ff @(posedge io_clk or posedge io_reset) begin
        if (io_reset) begin
            loopback_set   <= '0;
            link_reset_req <= '0;
            link_down_any  <= 1'b0;
        end else begin
            link_reset_req <= wd_fire;
            link_down_any  <= |timeout_flag;
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (wr_lb[c]) begin
                    loopback_set[3*c +: 3] <= io_wr_data[2:0];
                end
            end
        end
    end

    // Read mux; unmapped channels and registers read as zero.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (acc_chan == 4'(c)) begin
                case (acc_reg)
                    REG_STATUS:   rd_word = {26'b0, timeout_flag[c], chan_q[c], channel_up[c],
                                             lane_up[c], hard_err[c], frame_err[c]};
                    REG_SOFT:     rd_word = 32'(soft_cnt[c]);
                    REG_HARD:     rd_word = 32'(hard_cnt[c]);
                    REG_FRAME:    rd_word = 32'(frame_cnt[c]);
                    REG_DROP:     rd_word = 32'(drop_cnt[c]);
                    REG_LOOPBACK: rd_word = {29'b0, loopback_set[3*c +: 3]};
                    default:      rd_word = '0;
                endcase
            end
        end
    end

    always_ff @(posedge io_clk or posedge io_reset) begin
        if (io_reset) begin
            io_rd_data <= '0;
            io_rd_ack  <= 1'b0;
        end else begin
            io_rd_ack <= rd_stb;
            if (rd_stb) begin
                io_rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_multi_chan_link_monitor.sv
// Directed bench for multi_chan_link_monitor: register-map table plus
// hand-written sequences for counters, saturation, watchdog and reset.
module tb_multi_chan_link_monitor;

    localparam int unsigned NC = 4;

    logic              io_clk;
    logic              io_reset;
    logic              io_sel;
    logic              io_sync;
    logic [19:0]       io_addr;
    logic              io_rd_en;
    logic              io_wr_en;
    logic [31:0]       io_wr_data;
    logic [31:0]       io_rd_data;
    logic              io_rd_ack;
    logic [NC-1:0]     frame_err;
    logic [NC-1:0]     hard_err;
    logic [NC-1:0]     soft_err;
    logic [NC-1:0]     channel_up;
    logic [NC-1:0]     lane_up;
    logic [3*NC-1:0]   loopback_set;
    logic [NC-1:0]     link_reset_req;
    logic              link_down_any;

    int total = 0;
    int bad   = 0;

    multi_chan_link_monitor #(
        .NUM_CHAN      (NC),
        .CNT_WIDTH     (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .io_clk        (io_clk),
        .io_reset      (io_reset),
        .io_sel        (io_sel),
        .io_sync       (io_sync),
        .io_addr       (io_addr),
        .io_rd_en      (io_rd_en),
        .io_wr_en      (io_wr_en),
        .io_wr_data    (io_wr_data),
        .io_rd_data    (io_rd_data),
        .io_rd_ack     (io_rd_ack),
        .frame_err     (frame_err),
        .hard_err      (hard_err),
        .soft_err      (soft_err),
        .channel_up    (channel_up),
        .lane_up       (lane_up),
        .loopback_set  (loopback_set),
        .link_reset_req(link_reset_req),
        .link_down_any (link_down_any)
    );

    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    typedef struct {
        bit          is_wr;
        logic [3:0]  ch;
        logic [3:0]  rg;
        logic [31:0] data;
        logic [11:0] exp_lb;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the sampled result.
    task automatic do_read(input logic [3:0] ch, input logic [3:0] rg,
                           output logic [31:0] data, output logic ack);
        io_addr  = {12'h000, ch, rg};
        io_sel   = 1'b1;
        io_sync  = 1'b1;
        io_rd_en = 1'b1;
        io_wr_en = 1'b0;
        @(negedge io_clk);
        io_sel   = 1'b0;
        io_sync  = 1'b0;
        io_rd_en = 1'b0;
        data = io_rd_data;
        ack  = io_rd_ack;
    endtask

    task automatic do_write(input logic [3:0] ch, input logic [3:0] rg,
                            input logic [31:0] wdata, input logic with_rd);
        io_addr    = {12'h000, ch, rg};
        io_wr_data = wdata;
        io_sel     = 1'b1;
        io_sync    = 1'b1;
        io_wr_en   = 1'b1;
        io_rd_en   = with_rd;
        @(negedge io_clk);
        io_sel   = 1'b0;
        io_sync  = 1'b0;
        io_wr_en = 1'b0;
        io_rd_en = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] ch, input logic [3:0] rg,
                            input logic [31:0] exp);
        logic [31:0] d;
        logic        a;
        do_read(ch, rg, d, a);
        check({name, "_ack"}, 64'(a), 64'(1'b1));
        check(name, 64'(d), 64'(exp));
    endtask

    logic [31:0] rdat;
    logic        rack;
    logic [63:0] req_obs;
    logic [63:0] req_exp;
    logic [63:0] ld_obs;
    logic [63:0] ld_exp;
    logic [2:0]  other_req;

    initial begin
        vecs[0]  = '{1'b0, 4'd0,  4'd0, 32'h0000_001C, 12'h000};
        vecs[1]  = '{1'b1, 4'd3,  4'd5, 32'h0000_0005, 12'hA00};
        vecs[2]  = '{1'b0, 4'd3,  4'd5, 32'h0000_0005, 12'hA00};
        vecs[3]  = '{1'b0, 4'd0,  4'd5, 32'h0000_0000, 12'hA00};
        vecs[4]  = '{1'b0, 4'd15, 4'd0, 32'h0000_0000, 12'hA00};
        vecs[5]  = '{1'b0, 4'd3,  4'd6, 32'h0000_0000, 12'hA00};
        vecs[6]  = '{1'b0, 4'd3,  4'd9, 32'h0000_0000, 12'hA00};
        vecs[7]  = '{1'b1, 4'd3,  4'd9, 32'h0000_0007, 12'hA00};
        vecs[8]  = '{1'b1, 4'd7,  4'd5, 32'h0000_0007, 12'hA00};
        vecs[9]  = '{1'b1, 4'd1,  4'd5, 32'hFFFF_FFF2, 12'hA10};
        vecs[10] = '{1'b0, 4'd1,  4'd5, 32'h0000_0002, 12'hA10};
        vecs[11] = '{1'b0, 4'd2,  4'd1, 32'h0000_0000, 12'hA10};
        vecs[12] = '{1'b1, 4'd2,  4'd6, 32'h0000_0003, 12'hA10};
        vecs[13] = '{1'b0, 4'd1,  4'd0, 32'h0000_001C, 12'hA10};

        io_reset   = 1'b1;
        io_sel     = 1'b0;
        io_sync    = 1'b0;
        io_addr    = '0;
        io_rd_en   = 1'b0;
        io_wr_en   = 1'b0;
        io_wr_data = '0;
        frame_err  = '0;
        hard_err   = '0;
        soft_err   = '0;
        channel_up = '1;
        lane_up    = '1;

        repeat (2) @(negedge io_clk);
        check("rst_rd_data", 64'(io_rd_data), 64'h0);
        check("rst_rd_ack", 64'(io_rd_ack), 64'h0);
        check("rst_loopback", 64'(loopback_set), 64'h0);
        check("rst_link_req", 64'(link_reset_req), 64'h0);
        check("rst_link_down", 64'(link_down_any), 64'h0);
        io_reset = 1'b0;
        repeat (2) @(negedge io_clk);

        // Ack is a single-cycle pulse; data holds afterwards.
        rd_check("first_read", 4'd0, 4'd0, 32'h1C);
        @(negedge io_clk);
        check("ack_one_cycle", 64'(io_rd_ack), 64'h0);
        check("rd_data_hold", 64'(io_rd_data), 64'h1C);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].ch, vecs[i].rg, vecs[i].data, 1'b0);
            end else begin
                do_read(vecs[i].ch, vecs[i].rg, rdat, rack);
                check($sformatf("vec%0d_ack", i), 64'(rack), 64'h1);
                check($sformatf("vec%0d_data", i), 64'(rdat), 64'(vecs[i].data));
            end
            check($sformatf("vec%0d_lb", i), 64'(loopback_set), 64'(vecs[i].exp_lb));
        end

        // Sync without select does nothing.
        io_addr = 20'h00000; io_sync = 1'b1; io_sel = 1'b0; io_rd_en = 1'b1;
        @(negedge io_clk);
        io_sync = 1'b0; io_rd_en = 1'b0;
        check("nosel_ack", 64'(io_rd_ack), 64'h0);

        // Read+write together is a write with no ack.
        do_write(4'd0, 4'd5, 32'h3, 1'b1);
        check("rdwr_ack", 64'(io_rd_ack), 64'h0);
        check("rdwr_lb", 64'(loopback_set), 64'hA13);

        // soft_err[2]: five 3-cycle pulses, then a long hold counts once.
        for (int p = 0; p < 5; p++) begin
            soft_err[2] = 1'b1;
            repeat (3) @(negedge io_clk);
            soft_err[2] = 1'b0;
            repeat (2) @(negedge io_clk);
        end
        rd_check("soft5", 4'd2, 4'd1, 32'd5);
        soft_err[2] = 1'b1;
        repeat (100) @(negedge io_clk);
        rd_check("soft6", 4'd2, 4'd1, 32'd6);
        soft_err[2] = 1'b0;
        rd_check("hard_ch2_zero", 4'd2, 4'd2, 32'd0);

        // hard_err[1]: 20 pulses saturate a 4-bit counter at 15.
        for (int p = 0; p < 20; p++) begin
            hard_err[1] = 1'b1;
            @(negedge io_clk);
            hard_err[1] = 1'b0;
            @(negedge io_clk);
        end
        rd_check("hard_sat", 4'd1, 4'd2, 32'd15);
        rd_check("hard_sat2", 4'd1, 4'd2, 32'd15);
        hard_err[1] = 1'b1;
        do_write(4'd1, 4'd6, 32'h1, 1'b0);
        rd_check("clear_wins", 4'd1, 4'd2, 32'd0);
        rd_check("status_hard", 4'd1, 4'd0, 32'h1E);
        hard_err[1] = 1'b0;
        @(negedge io_clk);
        hard_err[1] = 1'b1;
        rd_check("pre_incr", 4'd1, 4'd2, 32'd0);
        rd_check("post_incr", 4'd1, 4'd2, 32'd1);
        hard_err[1] = 1'b0;
        @(negedge io_clk);

        // Watchdog on ch3; a flag clear coincides with the second fire.
        req_obs   = '0;
        ld_obs    = '0;
        other_req = '0;
        channel_up[3] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 31) begin
                io_addr = {12'h000, 4'd3, 4'd6}; io_wr_data = 32'h2;
                io_sync = 1'b1; io_sel = 1'b1; io_wr_en = 1'b1;
            end
            @(negedge io_clk);
            io_sync = 1'b0; io_sel = 1'b0; io_wr_en = 1'b0;
            req_obs[i] = link_reset_req[3];
            ld_obs[i]  = link_down_any;
            other_req  = other_req | link_reset_req[2:0];
        end
        req_exp = '0;
        ld_exp  = '0;
        for (int i = 0; i < 50; i++) begin
            req_exp[i] = (i == 15) || (i == 31) || (i == 47);
            ld_exp[i]  = (i >= 16);
        end
        check("wd_req_pattern", req_obs, req_exp);
        check("wd_link_down", ld_obs, ld_exp);
        check("wd_other_req", 64'(other_req), 64'h0);
        rd_check("wd_status", 4'd3, 4'd0, 32'h24);
        rd_check("wd_drop_cnt", 4'd3, 4'd4, 32'd1);
        channel_up[3] = 1'b1;
        do_write(4'd3, 4'd6, 32'h2, 1'b0);
        rd_check("wd_cleared", 4'd3, 4'd0, 32'h1C);
        check("wd_ld_clear", 64'(link_down_any), 64'h0);
        rd_check("wd_drop_kept", 4'd3, 4'd4, 32'd1);

        // Reset lands while a read is in flight.
        io_addr = {12'h000, 4'd2, 4'd1}; io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1;
        #2;
        io_reset = 1'b1;
        @(negedge io_clk);
        io_sel = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0;
        check("rst_mid_ack", 64'(io_rd_ack), 64'h0);
        check("rst_mid_data", 64'(io_rd_data), 64'h0);
        check("rst_mid_lb", 64'(loopback_set), 64'h0);
        io_reset = 1'b0;
        repeat (2) @(negedge io_clk);
        rd_check("rst_soft", 4'd2, 4'd1, 32'd0);
        rd_check("rst_hard", 4'd1, 4'd2, 32'd0);
        rd_check("rst_drop", 4'd3, 4'd4, 32'd0);
        rd_check("rst_lb_rd", 4'd3, 4'd5, 32'd0);
        rd_check("rst_status", 4'd3, 4'd0, 32'h1C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
